// File: rtl/alsu_pkg.sv
// Shared ALSU pin-interface types: opcode and pin-word encodings, the parked
// pin word, command-master FSM states and the invalid-combination predicate.
package alsu_pkg;

  typedef enum logic [2:0] {
    OP_OR        = 3'd0,
    OP_XOR       = 3'd1,
    OP_ADD       = 3'd2,
    OP_MULT      = 3'd3,
    OP_SHIFT     = 3'd4,
    OP_ROTATE    = 3'd5,
    OP_INVALID_6 = 3'd6,
    OP_INVALID_7 = 3'd7
  } opcode_e;

  typedef struct packed {
    opcode_e    opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic       serial_in;
    logic       direction;
    logic       red_op_a;
    logic       red_op_b;
    logic       bypass_a;
    logic       bypass_b;
  } alsu_pins_t;

  // Parked word: OR of A=B=0 with every control low, so the ALSU output settles to 0.
  localparam alsu_pins_t PARK_PINS = '{
    opcode:    OP_OR,
    a:         3'd0,
    b:         3'd0,
    cin:       1'b0,
    serial_in: 1'b0,
    direction: 1'b0,
    red_op_a:  1'b0,
    red_op_b:  1'b0,
    bypass_a:  1'b0,
    bypass_b:  1'b0
  };

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  function automatic logic alsu_invalid(input alsu_pins_t pins);
    logic [2:0] op;
    op = pins.opcode;
    return ((pins.red_op_a | pins.red_op_b) & (op[1] | op[2])) | (op[1] & op[2]);
  endfunction

endpackage

// File: rtl/alsu_cmd_master.sv
// Command master for the ALSU pin interface: takes one request, drives the
// ALSU pins for seed + repeat + 1 cycles, then returns the captured result.
module alsu_cmd_master
  import alsu_pkg::*;
#(
  parameter int ALSU_LATENCY = 2,
  parameter int REP_W        = 3,
  parameter int LEDS_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [2:0]        cmd_A,
  input  logic [2:0]        cmd_B,
  input  logic              cmd_cin,
  input  logic              cmd_serial_in,
  input  logic              cmd_direction,
  input  logic              cmd_red_op_A,
  input  logic              cmd_red_op_B,
  input  logic              cmd_bypass_A,
  input  logic              cmd_bypass_B,
  input  logic              cmd_seed,
  input  logic [REP_W-1:0]  cmd_repeat,
  output logic [2:0]        alsu_opcode,
  output logic [2:0]        alsu_A,
  output logic [2:0]        alsu_B,
  output logic              alsu_cin,
  output logic              alsu_serial_in,
  output logic              alsu_direction,
  output logic              alsu_red_op_A,
  output logic              alsu_red_op_B,
  output logic              alsu_bypass_A,
  output logic              alsu_bypass_B,
  input  logic [5:0]        alsu_out,
  input  logic [LEDS_W-1:0] alsu_leds,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [5:0]        rsp_out,
  output logic [LEDS_W-1:0] rsp_leds,
  output logic              rsp_invalid
);

  // Drain counts 0..ALSU_LATENCY-1 after the park edge; capture on the last count.
  localparam int DRAIN_W = (ALSU_LATENCY > 1) ? $clog2(ALSU_LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(ALSU_LATENCY - 1);

  state_e              state_q, state_d;
  logic [REP_W-1:0]    cnt_q, cnt_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  alsu_pins_t          cmd_q, cmd_d;
  alsu_pins_t          pins_q, pins_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [5:0]          rsp_out_q, rsp_out_d;
  logic [LEDS_W-1:0]   rsp_leds_q, rsp_leds_d;
  logic                rsp_invalid_q, rsp_invalid_d;
  alsu_pins_t          cmd_in_s;
  alsu_pins_t          seed_word_s;

  // Pack the command fields into a pin word and build the bypass-A seed word.
  always_comb begin
    cmd_in_s.opcode    = opcode_e'(cmd_opcode);
    cmd_in_s.a         = cmd_A;
    cmd_in_s.b         = cmd_B;
    cmd_in_s.cin       = cmd_cin;
    cmd_in_s.serial_in = cmd_serial_in;
    cmd_in_s.direction = cmd_direction;
    cmd_in_s.red_op_a  = cmd_red_op_A;
    cmd_in_s.red_op_b  = cmd_red_op_B;
    cmd_in_s.bypass_a  = cmd_bypass_A;
    cmd_in_s.bypass_b  = cmd_bypass_B;
    seed_word_s          = PARK_PINS;
    seed_word_s.a        = cmd_A;
    seed_word_s.bypass_a = 1'b1;
  end

  // Next-state, pin-word and response-capture logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    cmd_d         = cmd_q;
    pins_d        = pins_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_out_d     = rsp_out_q;
    rsp_leds_d    = rsp_leds_q;
    rsp_invalid_d = rsp_invalid_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d = cmd_in_s;
          cnt_d = cmd_repeat;
          if (cmd_seed) begin
            pins_d  = seed_word_s;
            state_d = ST_SEED;
          end else begin
            pins_d  = cmd_in_s;
            state_d = ST_RUN;
          end
        end else begin
          pins_d = PARK_PINS;
        end
      end
      ST_SEED: begin
        pins_d  = cmd_q;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // cnt_q holds the remaining extra cycles; the ALSU itself advances shift/rotate.
        if (cnt_q == '0) begin
          pins_d  = PARK_PINS;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d  = cnt_q - REP_W'(1);
          pins_d = cmd_q;
        end
      end
      ST_DRAIN: begin
        pins_d = PARK_PINS;
        if (drain_q == DRAIN_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_out_d     = alsu_out;
          rsp_leds_d    = alsu_leds;
          rsp_invalid_d = alsu_invalid(cmd_q);
          state_d       = ST_RESP;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      ST_RESP: begin
        pins_d = PARK_PINS;
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        pins_d      = PARK_PINS;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, drive and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      drain_q       <= '0;
      cmd_q         <= PARK_PINS;
      pins_q        <= PARK_PINS;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_out_q     <= 6'd0;
      rsp_leds_q    <= '0;
      rsp_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      drain_q       <= drain_d;
      cmd_q         <= cmd_d;
      pins_q        <= pins_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_out_q     <= rsp_out_d;
      rsp_leds_q    <= rsp_leds_d;
      rsp_invalid_q <= rsp_invalid_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign alsu_opcode    = pins_q.opcode;
  assign alsu_A         = pins_q.a;
  assign alsu_B         = pins_q.b;
  assign alsu_cin       = pins_q.cin;
  assign alsu_serial_in = pins_q.serial_in;
  assign alsu_direction = pins_q.direction;
  assign alsu_red_op_A  = pins_q.red_op_a;
  assign alsu_red_op_B  = pins_q.red_op_b;
  assign alsu_bypass_A  = pins_q.bypass_a;
  assign alsu_bypass_B  = pins_q.bypass_b;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_out        = rsp_out_q;
  assign rsp_leds       = rsp_leds_q;
  assign rsp_invalid    = rsp_invalid_q;

endmodule

// File: tb/tb_alsu_cmd_master.sv
// Directed bench for alsu_cmd_master with a behavioural two-stage ALSU on the
// pin side and a queue of expected responses.
module tb_alsu_cmd_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode, cmd_A, cmd_B;
  logic        cmd_cin, cmd_serial_in, cmd_direction, cmd_red_op_A, cmd_red_op_B;
  logic        cmd_bypass_A, cmd_bypass_B, cmd_seed;
  logic [2:0]  cmd_repeat;
  logic [2:0]  alsu_opcode, alsu_A, alsu_B;
  logic        alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A, alsu_red_op_B;
  logic        alsu_bypass_A, alsu_bypass_B;
  logic        rsp_valid, rsp_ready, rsp_invalid;
  logic [5:0]  rsp_out;
  logic [15:0] rsp_leds;
  logic [15:0] pins_all;

  typedef struct {
    string       tag;
    logic [5:0]  out;
    logic [15:0] leds;
    logic        inv;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_cnt = 0;
  int   accept_edge = 0;
  int   hs_edge = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assign pins_all = {alsu_opcode, alsu_A, alsu_B, alsu_cin, alsu_serial_in, alsu_direction,
                     alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B};

  // Behavioural ALSU: input register, then output register fed back for shift/rotate.
  logic [2:0]  r_op, r_a, r_b;
  logic        r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb;
  logic [5:0]  m_out, m_next;
  logic [15:0] m_leds;
  logic        m_inv;

  always_comb begin
    m_inv  = ((r_ra | r_rb) & (r_op[1] | r_op[2])) | (r_op[1] & r_op[2]);
    m_next = 6'd0;
    if (m_inv) m_next = 6'd0;
    else if (r_ba) m_next = {3'd0, r_a};
    else if (r_bb) m_next = {3'd0, r_b};
    else begin
      case (r_op)
        3'd0: m_next = r_ra ? {5'd0, |r_a} : (r_rb ? {5'd0, |r_b} : {3'd0, r_a | r_b});
        3'd1: m_next = r_ra ? {5'd0, ^r_a} : (r_rb ? {5'd0, ^r_b} : {3'd0, r_a ^ r_b});
        3'd2: m_next = {3'd0, r_a} + {3'd0, r_b} + {5'd0, r_cin};
        3'd3: m_next = {3'd0, r_a} * {3'd0, r_b};
        3'd4: m_next = r_dir ? {m_out[4:0], r_sin} : {r_sin, m_out[5:1]};
        3'd5: m_next = r_dir ? {m_out[4:0], m_out[5]} : {m_out[0], m_out[5:1]};
        default: m_next = 6'd0;
      endcase
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      {r_op, r_a, r_b, r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb} <= 16'd0;
      m_out  <= 6'd0;
      m_leds <= 16'd0;
    end else begin
      {r_op, r_a, r_b, r_cin, r_sin, r_dir, r_ra, r_rb, r_ba, r_bb} <= pins_all;
      m_out  <= m_next;
      m_leds <= m_inv ? 16'hFFFF : 16'd0;
    end
  end

  alsu_cmd_master #(.ALSU_LATENCY(2), .REP_W(3), .LEDS_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_A(cmd_A), .cmd_B(cmd_B),
    .cmd_cin(cmd_cin), .cmd_serial_in(cmd_serial_in), .cmd_direction(cmd_direction),
    .cmd_red_op_A(cmd_red_op_A), .cmd_red_op_B(cmd_red_op_B),
    .cmd_bypass_A(cmd_bypass_A), .cmd_bypass_B(cmd_bypass_B),
    .cmd_seed(cmd_seed), .cmd_repeat(cmd_repeat),
    .alsu_opcode(alsu_opcode), .alsu_A(alsu_A), .alsu_B(alsu_B),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_out(m_out), .alsu_leds(m_leds),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_leds(rsp_leds), .rsp_invalid(rsp_invalid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command, wait (bounded) for acceptance and queue its expected response.
  task automatic issue(input string tag, input logic [2:0] op, input logic [2:0] a,
                       input logic [2:0] b, input logic cin, input logic sin, input logic dir,
                       input logic ra, input logic seed, input logic [2:0] rep,
                       input logic [5:0] e_out, input logic [15:0] e_leds, input logic e_inv);
    exp_t e;
    cmd_opcode = op; cmd_A = a; cmd_B = b; cmd_cin = cin; cmd_serial_in = sin;
    cmd_direction = dir; cmd_red_op_A = ra; cmd_red_op_B = 1'b0;
    cmd_bypass_A = 1'b0; cmd_bypass_B = 1'b0; cmd_seed = seed; cmd_repeat = rep;
    cmd_valid = 1'b1;
    e.tag = tag; e.out = e_out; e.leds = e_leds; e.inv = e_inv;
    e.lat = int'(seed) + int'(rep) + 1 + 2;
    sb.push_back(e);
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    accept_edge = edge_cnt + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare against the queue, optionally stall, then handshake.
  task automatic get_rsp(input int hold);
    exp_t e;
    int   rise;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    rise = edge_cnt;
    chk("rsp_seen", 32'(rsp_valid), 32'd1);
    chk("sb_depth", 32'(sb.size()), 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.tag = "none"; e.out = 6'd0; e.leds = 16'd0; e.inv = 1'b0; e.lat = 0;
    end
    chk({e.tag, "_out"}, 32'(rsp_out), 32'(e.out));
    chk({e.tag, "_leds"}, 32'(rsp_leds), 32'(e.leds));
    chk({e.tag, "_invalid"}, 32'(rsp_invalid), 32'(e.inv));
    chk({e.tag, "_latency"}, 32'(rise - accept_edge), 32'(e.lat));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({e.tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({e.tag, "_hold_out"}, 32'(rsp_out), 32'(e.out));
      chk({e.tag, "_hold_leds"}, 32'(rsp_leds), 32'(e.leds));
      chk({e.tag, "_hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    hs_edge = edge_cnt + 1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({e.tag, "_valid_clear"}, 32'(rsp_valid), 32'd0);
    chk({e.tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_A = 3'd0; cmd_B = 3'd0; cmd_cin = 1'b0;
    cmd_serial_in = 1'b0; cmd_direction = 1'b0; cmd_red_op_A = 1'b0; cmd_red_op_B = 1'b0;
    cmd_bypass_A = 1'b0; cmd_bypass_B = 1'b0; cmd_seed = 1'b0; cmd_repeat = 3'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_out", 32'(rsp_out), 32'd0);
    chk("rst_rsp_leds", 32'(rsp_leds), 32'd0);
    chk("rst_rsp_invalid", 32'(rsp_invalid), 32'd0);
    chk("rst_pins_park", 32'(pins_all), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // ADD 3+5+cin
    issue("add", 3'd2, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd9, 16'd0, 1'b0);
    get_rsp(0);

    // MULT, with XOR presented before the MULT response is consumed
    issue("mult", 3'd3, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd49, 16'd0, 1'b0);
    cmd_opcode = 3'd1; cmd_A = 3'd6; cmd_B = 3'd3; cmd_valid = 1'b1;
    get_rsp(0);
    issue("xor", 3'd1, 3'd6, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd5, 16'd0, 1'b0);
    chk("b2b_accept_edge", 32'(accept_edge), 32'(hs_edge + 1));
    get_rsp(0);

    // Seeded left shift with serial_in=1: ALSU output walks 5, 11, 23, 47
    issue("shift_seed", 3'd4, 3'd5, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 6'd47, 16'd0, 1'b0);
    @(negedge clk);
    @(negedge clk); chk("shift_seq0", 32'(m_out), 32'd5);
    @(negedge clk); chk("shift_seq1", 32'(m_out), 32'd11);
    @(negedge clk); chk("shift_seq2", 32'(m_out), 32'd23);
    @(negedge clk); chk("shift_seq3", 32'(m_out), 32'd47);
    get_rsp(0);

    // Rotates, including the maximum repeat count
    issue("rot_right", 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 6'd32, 16'd0, 1'b0);
    get_rsp(0);
    issue("rot_left8", 3'd5, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd7, 6'd4, 16'd0, 1'b0);
    get_rsp(0);

    // Invalid opcode, then a valid reduction OR
    issue("inv_op6", 3'd6, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd0, 16'hFFFF, 1'b1);
    get_rsp(0);
    issue("or_red_a", 3'd0, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 6'd1, 16'd0, 1'b0);
    get_rsp(0);

    // Response backpressure for five cycles
    issue("bp_add", 3'd2, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd3, 16'd0, 1'b0);
    get_rsp(5);

    // Reset pulse in the middle of a long shift run
    issue("rst_shift", 3'd4, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 6'd0, 16'd0, 1'b0);
    @(negedge clk);
    chk("run_pins_opcode", 32'(alsu_opcode), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("async_pins_park", 32'(pins_all), 32'd0);
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    sb.delete(sb.size() - 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (12) @(negedge clk);
    chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    chk("post_rst_pins_park", 32'(pins_all), 32'd0);
    issue("post_rst_add", 3'd2, 3'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 6'd4, 16'd0, 1'b0);
    get_rsp(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
